// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

   // Shift mode encodings as seen on the MODE port.
   typedef enum logic [1:0] {
      MODE_SLL = 2'b00,
      MODE_SRL = 2'b01,
      MODE_SRA = 2'b10,
      MODE_ROL = 2'b11
   } mode_e;

   // Stage-record field widths that do not depend on WIDTH.
   localparam int MODE_W = 2;
   localparam int FLAG_W = 1;

endpackage

// File: rtl/shift_stage.sv
// One shift level: shifts by the constant AMT when do_shift is set, per mode.
// Latency: combinational; the owning pipeline registers the result.
// Backpressure: none here; stalls are handled by the pipeline registers.
//
// Ports:
//   dat      operand entering this level
//   mode     shift mode (shift_pkg::mode_e encoding)
//   sign     operand MSB captured at pipeline entry (SRA fill value)
//   do_shift this level's bit of the shift amount
//   ovf_prev overflow accumulated by earlier levels
//   res      shifted operand
//   ovf      updated overflow (only ever set in SLL)
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT   = 1
) (
   input  logic [WIDTH-1:0]  dat,
   input  logic [MODE_W-1:0] mode,
   input  logic              sign,
   input  logic              do_shift,
   input  logic              ovf_prev,
   output logic [WIDTH-1:0]  res,
   output logic              ovf
);

   // Bits that leave through the MSB on a left shift / rotate.
   logic [AMT-1:0] top_bits;
   assign top_bits = dat[WIDTH-1 -: AMT];

   always_comb begin
      res = dat;
      ovf = ovf_prev;
      if (do_shift) begin
         case (mode_e'(mode))
            MODE_SLL: begin
               res = {dat[WIDTH-1-AMT:0], {AMT{1'b0}}};
               ovf = ovf_prev | (|top_bits);
            end
            MODE_SRL: res = {{AMT{1'b0}}, dat[WIDTH-1:AMT]};
            // Fill comes from the sign captured at entry, not the current
            // MSB, so earlier levels cannot corrupt the fill value.
            MODE_SRA: res = {{AMT{sign}}, dat[WIDTH-1:AMT]};
            MODE_ROL: res = {dat[WIDTH-1-AMT:0], top_bits};
            default:  res = dat;
         endcase
      end
   end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL), one register per shift level.
// Latency: SW = log2(WIDTH) cycles from accept to OUT_VALID, one result/cycle.
// Backpressure: whole pipe stalls when OUT_VALID & !OUT_READY; IN_READY drops.
//
// Ports:
//   CLK, RST             rising-edge clock, synchronous active-high reset
//   IN_VALID/IN_READY    operand handshake; D operand, S amount, MODE mode
//   OUT_VALID/OUT_READY  result handshake; Y result, OVF SLL overflow flag
// WIDTH must be a power of two, at least 4.
module shift_pipe
   import shift_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SW    = $clog2(WIDTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [WIDTH-1:0]  D,
   input  logic [SW-1:0]     S,
   input  logic [MODE_W-1:0] MODE,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [WIDTH-1:0]  Y,
   output logic              OVF
);

   typedef struct packed {
      logic              vld;
      logic [WIDTH-1:0]  dat;
      logic [MODE_W-1:0] mode;
      logic [SW-1:0]     amt;
      logic              sign;
      logic [FLAG_W-1:0] ovf;
   } stage_t;

   stage_t pipe [SW];  // stage registers
   stage_t src  [SW];  // record feeding each shift level
   stage_t nxt  [SW];  // record after each shift level

   logic en;

   // Global advance: the only place a result can be blocked is the last
   // stage, so either everything moves or nothing does.
   assign en       = !pipe[SW-1].vld || OUT_READY;
   assign IN_READY = en;

   assign src[0] = '{vld:  IN_VALID,
                     dat:  D,
                     mode: MODE,
                     amt:  S,
                     sign: D[WIDTH-1],
                     ovf:  1'b0};

   genvar k;
   generate
      for (k = 0; k < SW; k++) begin : g_stage
         logic [WIDTH-1:0] res;
         logic             ovf;

         if (k > 0) begin : g_link
            assign src[k] = pipe[k-1];
         end

         shift_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << k)
         ) u_stage (
            .dat      (src[k].dat),
            .mode     (src[k].mode),
            .sign     (src[k].sign),
            .do_shift (src[k].amt[k]),
            .ovf_prev (src[k].ovf),
            .res      (res),
            .ovf      (ovf)
         );

         assign nxt[k] = '{vld:  src[k].vld,
                           dat:  res,
                           mode: src[k].mode,
                           amt:  src[k].amt,
                           sign: src[k].sign,
                           ovf:  ovf};
      end
   endgenerate

   // Empty slots still clock their (don't-care) data; only vld matters.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < SW; i++) pipe[i] <= '0;
      end else if (en) begin
         for (int i = 0; i < SW; i++) pipe[i] <= nxt[i];
      end
   end

   assign OUT_VALID = pipe[SW-1].vld;
   assign Y         = pipe[SW-1].dat;
   assign OVF       = pipe[SW-1].ovf;

   // Control fields of the final record have no consumer past the last level.
   logic unused_tail;
   assign unused_tail = ^{pipe[SW-1].mode, pipe[SW-1].amt, pipe[SW-1].sign};

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;

   localparam int W   = 32;
   localparam int SWB = 5;

   logic          CLK;
   logic          RST;
   logic          IN_VALID;
   logic          IN_READY;
   logic [W-1:0]  D;
   logic [4:0]    S;
   logic [1:0]    MODE;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [W-1:0]  Y;
   logic          OVF;

   shift_pipe #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .D         (D),
      .S         (S),
      .MODE      (MODE),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .Y         (Y),
      .OVF       (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] y;
      logic        ovf;
      int          acc_cyc;
      bit          lat_chk;
   } exp_t;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  s;
      logic [1:0]  mode;
      logic [31:0] y;
      logic        ovf;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[11];
   int          checks;
   int          failures;
   int          cyc;
   int          pops;
   bit          lat_next;
   bit          accepted;
   logic [31:0] exp_y_in;
   logic        exp_ovf_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference shifter written directly from the mode definitions.
   function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] s,
                                         input logic [1:0] m);
      logic [63:0] w;
      logic [31:0] y;
      logic        o;
      w = {32'b0, d} << s;
      o = 1'b0;
      case (m)
         2'b00: begin y = w[31:0]; o = |w[63:32]; end
         2'b01: y = d >> s;
         2'b10: y = $unsigned($signed(d) >>> s);
         default: y = w[31:0] | w[63:32];
      endcase
      return {o, y};
   endfunction

   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] m, input logic [31:0] ey, input logic eo);
      IN_VALID   = v;
      D          = d;
      S          = s;
      MODE       = m;
      exp_y_in   = ey;
      exp_ovf_in = eo;
   endtask

   task automatic drive_model(input logic v, input logic [31:0] d, input logic [4:0] s,
                              input logic [1:0] m);
      logic [32:0] r;
      r = model(d, s, m);
      drive(v, d, s, m, r[31:0], r[32]);
   endtask

   // One cycle, entered and left at a falling edge. Both handshakes are
   // judged on settled values shortly after the falling edge.
   task automatic tick();
      exp_t e;
      #1;
      if (OUT_VALID && OUT_READY) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got Y=0x%08h with nothing pending", Y);
         end else begin
            e = sb.pop_front();
            pops++;
            chk("result_y", Y, e.y);
            chk("result_ovf", {31'b0, OVF}, {31'b0, e.ovf});
            if (e.lat_chk) chk("latency", cyc - e.acc_cyc, SWB);
         end
      end
      accepted = IN_VALID && IN_READY && !RST;
      if (accepted) begin
         e.y       = exp_y_in;
         e.ovf     = exp_ovf_in;
         e.acc_cyc = cyc;
         e.lat_chk = lat_next;
         sb.push_back(e);
      end
      cyc++;
      @(negedge CLK);
   endtask

   task automatic drain();
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      for (int i = 0; i < 60 && sb.size() > 0; i++) tick();
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held_y;
      int          issued;
      int          pops0;

      checks = 0; failures = 0; cyc = 0; pops = 0; lat_next = 0; accepted = 0;
      RST = 1'b1; OUT_READY = 1'b1;
      drive(1'b0, '0, '0, 2'b00, '0, 1'b0);

      vecs[0]  = '{32'h0000_0001, 5'd1,  2'b00, 32'h0000_0002, 1'b0};
      vecs[1]  = '{32'h0000_1234, 5'd0,  2'b00, 32'h0000_1234, 1'b0};
      vecs[2]  = '{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 1'b0};
      vecs[3]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0};
      vecs[4]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0};
      vecs[5]  = '{32'h8000_0001, 5'd1,  2'b11, 32'h0000_0003, 1'b0};
      vecs[6]  = '{32'hF000_0000, 5'd8,  2'b11, 32'h0000_00F0, 1'b0};
      vecs[7]  = '{32'h7FFF_FFFF, 5'd10, 2'b00, 32'hFFFF_FC00, 1'b1};
      vecs[8]  = '{32'd200,       5'd3,  2'b00, 32'd1600,      1'b0};
      vecs[9]  = '{32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000, 1'b1};
      vecs[10] = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 1'b0};

      @(negedge CLK);
      tick();
      tick();
      RST = 1'b0;
      #1;
      chk("reset_out_valid", {31'b0, OUT_VALID}, 32'd0);
      chk("reset_y", Y, 32'd0);
      chk("reset_ovf", {31'b0, OVF}, 32'd0);
      chk("reset_in_ready", {31'b0, IN_READY}, 32'd1);

      // First vector alone, with exact latency check.
      lat_next = 1'b1;
      drive(1'b1, vecs[0].d, vecs[0].s, vecs[0].mode, vecs[0].y, vecs[0].ovf);
      tick();
      lat_next = 1'b0;
      drain();

      // Remaining directed vectors back to back.
      for (int i = 1; i < 11; i++) begin
         drive(1'b1, vecs[i].d, vecs[i].s, vecs[i].mode, vecs[i].y, vecs[i].ovf);
         tick();
      end
      drain();

      // Stall and ordering: 8 distinct ops, consumer blocks cycles 7-9.
      issued = 0;
      pops0  = pops;
      for (int j = 0; j < 60 && (issued < 8 || sb.size() > 0); j++) begin
         if (issued < 8)
            drive_model(1'b1, 32'h1000_0000 + issued * 32'h0101_1111,
                        5'(issued * 3), 2'(issued));
         else
            IN_VALID = 1'b0;
         OUT_READY = !(j >= 7 && j <= 9);
         if (j >= 7 && j <= 9) begin
            #1;
            chk("stall_in_ready", {31'b0, IN_READY}, 32'd0);
            chk("stall_out_valid", {31'b0, OUT_VALID}, 32'd1);
            if (j == 7) held_y = Y;
            else chk("stall_hold_y", Y, held_y);
         end
         tick();
         if (accepted) issued++;
      end
      chk("stall_result_count", pops - pops0, 32'd8);
      drain();

      // Reset with three operations in flight.
      OUT_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_model(1'b1, 32'hA5A5_0000 + 32'(i), 5'(i + 1), 2'b00);
         tick();
      end
      IN_VALID = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      sb.delete();
      #1;
      chk("midreset_out_valid", {31'b0, OUT_VALID}, 32'd0);
      chk("midreset_y", Y, 32'd0);
      chk("midreset_in_ready", {31'b0, IN_READY}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("no_stale_result", {31'b0, OUT_VALID}, 32'd0);
         tick();
      end
      lat_next = 1'b1;
      drive_model(1'b1, 32'h0000_00FF, 5'd4, 2'b00);
      tick();
      lat_next = 1'b0;
      drain();

      // Random traffic with random backpressure.
      for (int i = 0; i < 200; i++) begin
         drive_model(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
                     2'($urandom_range(0, 3)));
         OUT_READY = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter.
- Next generation of the 32-bit combinational left shifter: generic width, four shift modes, one register per shift level.
- Uses a valid/ready handshake on both sides and a left-shift overflow flag.
- Sits in the ALU datapath as a multi-cycle shift unit. Stalls as a whole when the consumer is not ready.

Parameters:
- WIDTH, 32, data width in bits. Must be a power of 2, at least 4.
- SW, $clog2(WIDTH), shift-amount width. Also equals the number of pipeline stages (derived, not overridden).

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  synchronous reset, active-high.
- IN_VALID  input  1  operand valid.
- IN_READY  output  1  unit accepts an operand this cycle.
- D  input  WIDTH  operand.
- S  input  SW  shift amount, unsigned, 0..WIDTH-1.
- MODE  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- Y  output  WIDTH  result.
- OVF  output  1  SLL only: a 1 bit was shifted out of the MSB. 0 for all other modes.

Behaviour:
- Clocking: single clock CLK. RST is synchronous and active-high, sampled on the rising edge of CLK.
- Reset: all stage valid bits clear. OUT_VALID=0, Y=0, OVF=0.
  - Reset takes priority over everything. Any in-flight operations are discarded.
  - IN_READY=1 in the cycle after reset.
- Structure: SW stages. Stage k (k=0..SW-1) shifts its data by 2^k when bit k of the captured S is 1.
  - Each stage register holds: valid, data, MODE, the remaining S bits, the sign bit (D[WIDTH-1] at entry) and the accumulated OVF.
- Advance enable: en = !OUT_VALID | OUT_READY.
  - IN_READY = en, purely combinational.
  - When en=1 every stage advances together. When en=0 no stage changes.
  - No bubble collapsing; a global stall is the required behaviour.
- Accept: an operand is accepted on a rising edge with IN_VALID & IN_READY. Otherwise stage 0 loads valid=0.
- Latency: exactly SW cycles from accept to OUT_VALID=1, absent stalls (5 at WIDTH=32).
- Throughput: one result per cycle while OUT_READY stays high.
- Result hold: Y, OVF and OUT_VALID stay stable while OUT_VALID=1 and OUT_READY=0.
- Per-stage shift of 2^k bits, by mode:
  - SLL: zero fill on the right. OVF |= OR of the 2^k bits shifted out.
  - SRL: zero fill on the left.
  - SRA: fill on the left with the captured sign bit.
  - ROL: rotate left. Bits shifted out re-enter on the right.
- S=0: Y=D in all modes, OVF=0.
- Maximum shift (S=WIDTH-1):
  - SLL gives D[0]<<(WIDTH-1).
  - SRA of a negative operand gives all ones.
- Empty stage registers still clock. Their contents are don't-care, but Y must only be sampled while OUT_VALID=1.
- Simultaneous accept and output handshake in the same cycle is legal and loses nothing.
- Ordering: results leave in issue order. No drops, no duplicates.

Decomposition:
- Shared package (shift_pkg):
  - Mode encodings: MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROL=2'b11.
  - Stage-record field widths.
- One natural sub-module: shift_stage (parameters WIDTH, AMT=2^k).
  - Combinational mode mux plus OVF accumulation.
  - Instantiated SW times by a generate loop, with the registers in shift_pipe.

Test Plan (WIDTH=32):
1. SLL, D=1, S=1, OUT_READY=1 -> 5 cycles after accept: OUT_VALID=1, Y=2, OVF=0. Also S=0, D=0x1234 -> Y=0x1234.
2. D=0x80000000, S=4: SRL -> Y=0x08000000; SRA -> Y=0xF8000000. Also SRA D=0x80000000, S=31 -> Y=0xFFFFFFFF.
3. ROL, D=0x80000001, S=1 -> Y=0x00000003, OVF=0. Also ROL D=0xF0000000, S=8 -> Y=0x000000F0.
4. SLL, D=0x7FFFFFFF, S=10 -> Y=0xFFFFFC00, OVF=1. Also SLL D=200, S=3 -> Y=1600, OVF=0.
5. Stall and ordering:
   - Stimulus: 8 back-to-back ops with distinct D; OUT_READY=0 for cycles 7-9.
   - IN_READY=0 during the stall.
   - Y held stable through the stall.
   - All 8 results emerge in order, none lost or duplicated.
6. Reset mid-flight: RST=1 for 1 cycle with 3 ops in flight.
   - Next cycle: OUT_VALID=0, Y=0, IN_READY=1.
   - No stale result ever appears.
   - A new op issued after reset completes correctly in 5 cycles.
